// File: rtl/sfm_pkg.sv
// Shared types and constants for the softmax datapath controllers.
package sfm_pkg;

    localparam int RED_LEN_WIDTH = 16;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_STREAM,
        RS_DRAIN,
        RS_OUTPUT
    } red_sum_ctrl_state_e;

endpackage

// File: rtl/sfm_tail_strb_gen.sv
// Element strobe and last-beat flag for a row that still has 'rem' elements left.
module sfm_tail_strb_gen #(
    parameter int VECT_WIDTH = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic [LEN_WIDTH-1:0]  rem,
    output logic [VECT_WIDTH-1:0] strb,
    output logic                  is_last
);

    // Lane i is live while more than i elements remain; LSB is element 0.
    always_comb begin
        strb = '0;
        for (int i = 0; i < VECT_WIDTH; i++) begin
            strb[i] = (rem > LEN_WIDTH'(i));
        end
        is_last = (rem <= LEN_WIDTH'(VECT_WIDTH));
    end

endmodule

// File: rtl/sfm_red_sum_ctrl.sv
// Row sequencer for the FP reduction-sum unit: clears the reducer, streams a row's
// beats with a tail strobe, and returns the tagged final sum on a valid/ready port.
module sfm_red_sum_ctrl
    import sfm_pkg::*;
#(
    parameter int VECT_WIDTH = 4,
    parameter int IN_WIDTH   = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int LEN_WIDTH  = RED_LEN_WIDTH
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           cmd_valid_i,
    output logic                           cmd_ready_o,
    input  logic [LEN_WIDTH-1:0]           cmd_len_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [VECT_WIDTH*IN_WIDTH-1:0] in_data_i,
    output logic                           red_clear_o,
    output logic                           red_valid_o,
    input  logic                           red_ready_i,
    output logic [VECT_WIDTH*IN_WIDTH-1:0] red_vect_o,
    output logic [VECT_WIDTH-1:0]          red_strb_o,
    output logic                           red_tag_o,
    input  logic                           red_valid_i,
    input  logic                           red_tag_i,
    input  logic [ACC_WIDTH-1:0]           red_res_i,
    output logic                           red_out_rdy_o,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [ACC_WIDTH-1:0]           out_sum_o,
    output logic                           busy_o,
    output red_sum_ctrl_state_e            dbg_state_o
);

    // Handshakes: a transfer happens on any rising clk_i edge where valid and
    // ready are both high; valid never waits on ready, and the producer holds
    // its payload stable until the transfer.

    red_sum_ctrl_state_e state_q, state_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic [ACC_WIDTH-1:0] sum_q, sum_d;

    logic [VECT_WIDTH-1:0] tail_strb;
    logic                  tail_last;

    sfm_tail_strb_gen #(
        .VECT_WIDTH (VECT_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_tail (
        .rem     (rem_q),
        .strb    (tail_strb),
        .is_last (tail_last)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= RS_IDLE;
            rem_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        sum_d         = sum_q;
        cmd_ready_o   = 1'b0;
        in_ready_o    = 1'b0;
        red_clear_o   = 1'b0;
        red_valid_o   = 1'b0;
        red_vect_o    = '0;
        red_strb_o    = '0;
        red_tag_o     = 1'b0;
        red_out_rdy_o = 1'b0;
        out_valid_o   = 1'b0;
        out_sum_o     = '0;

        // While reset is asserted every output stays quiet; the register block
        // restores the idle state on the edge.
        if (!rst_ni) begin
            state_d = RS_IDLE;
        end else if (clear_i) begin
            state_d     = RS_IDLE;
            rem_d       = '0;
            sum_d       = '0;
            red_clear_o = 1'b1;
        end else begin
            unique case (state_q)
                RS_IDLE: begin
                    cmd_ready_o = 1'b1;
                    if (cmd_valid_i) begin
                        if (cmd_len_i != '0) begin
                            rem_d       = cmd_len_i;
                            red_clear_o = 1'b1;
                            state_d     = RS_STREAM;
                        end else begin
                            // An empty row sums to +0.0 without touching the reducer.
                            sum_d   = '0;
                            state_d = RS_OUTPUT;
                        end
                    end
                end
                RS_STREAM: begin
                    red_valid_o   = in_valid_i;
                    in_ready_o    = red_ready_i;
                    red_vect_o    = in_data_i;
                    red_strb_o    = tail_strb;
                    red_tag_o     = tail_last;
                    red_out_rdy_o = 1'b1;
                    if (in_valid_i && red_ready_i) begin
                        if (tail_last) begin
                            rem_d   = '0;
                            state_d = RS_DRAIN;
                        end else begin
                            rem_d = rem_q - LEN_WIDTH'(VECT_WIDTH);
                        end
                    end
                end
                RS_DRAIN: begin
                    // Untagged partial results are accepted and dropped.
                    red_out_rdy_o = 1'b1;
                    if (red_valid_i && red_tag_i) begin
                        sum_d   = red_res_i;
                        state_d = RS_OUTPUT;
                    end
                end
                RS_OUTPUT: begin
                    out_valid_o = 1'b1;
                    out_sum_o   = sum_q;
                    if (out_ready_i) begin
                        state_d = RS_IDLE;
                    end
                end
                default: begin
                    state_d = RS_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = rst_ni && (state_q != RS_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sfm_red_sum_ctrl.sv
// Directed bench for sfm_red_sum_ctrl with a behavioural reducer that sums the
// strobed fp16 lanes and returns an fp32 result a few cycles after the tagged beat.
module tb_sfm_red_sum_ctrl;
  import sfm_pkg::*;

  localparam logic [15:0] H1 = 16'h3C00;
  localparam logic [15:0] H2 = 16'h4000;
  localparam logic [15:0] H3 = 16'h4200;
  localparam logic [15:0] H4 = 16'h4400;
  localparam logic [15:0] H5 = 16'h4500;
  localparam logic [15:0] H6 = 16'h4600;
  localparam logic [15:0] HX = 16'h5A5A;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ni;
  logic        clear_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [15:0] cmd_len_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] in_data_i;
  logic        red_clear_o;
  logic        red_valid_o;
  logic        red_ready_i;
  logic [63:0] red_vect_o;
  logic [3:0]  red_strb_o;
  logic        red_tag_o;
  logic        red_valid_i;
  logic        red_tag_i;
  logic [31:0] red_res_i;
  logic        red_out_rdy_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_sum_o;
  logic        busy_o;
  red_sum_ctrl_state_e dbg_state;

  sfm_red_sum_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_len_i     (cmd_len_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_data_i     (in_data_i),
    .red_clear_o   (red_clear_o),
    .red_valid_o   (red_valid_o),
    .red_ready_i   (red_ready_i),
    .red_vect_o    (red_vect_o),
    .red_strb_o    (red_strb_o),
    .red_tag_o     (red_tag_o),
    .red_valid_i   (red_valid_i),
    .red_tag_i     (red_tag_i),
    .red_res_i     (red_res_i),
    .red_out_rdy_o (red_out_rdy_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_sum_o     (out_sum_o),
    .busy_o        (busy_o),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- number helpers ----------------
  function automatic int fp16_to_int(input logic [15:0] h);
    int e;
    int m;
    if (h[14:0] == 15'd0) return 0;
    e = int'(h[14:10]);
    m = int'({1'b1, h[9:0]});
    if (e >= 25) return m << (e - 25);
    return m >> (25 - e);
  endfunction

  function automatic logic [31:0] int_to_fp32(input int v);
    int p;
    logic [31:0] man;
    if (v <= 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 31; i++) if (v[i]) p = i;
    man = 32'(v) << (23 - p);
    return {1'b0, 8'(127 + p), man[22:0]};
  endfunction

  function automatic int beat_sum(input logic [63:0] d, input logic [3:0] s);
    int t;
    t = 0;
    for (int i = 0; i < 4; i++) if (s[i]) t += fp16_to_int(d[i*16 +: 16]);
    return t;
  endfunction

  function automatic logic [63:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  // ---------------- reducer model ----------------
  int          res_delay = 2;
  int          acc = 0;
  int          cnt = 0;
  logic        pend = 1'b0;
  logic        m_v = 1'b0;
  logic        m_tag = 1'b0;
  logic [31:0] m_res = 32'h0;

  assign red_valid_i = m_v;
  assign red_tag_i   = m_tag;
  assign red_res_i   = m_res;

  always @(posedge clk) begin
    if (red_clear_o) begin
      acc   <= 0;
      pend  <= 1'b0;
      m_v   <= 1'b0;
      m_tag <= 1'b0;
    end else begin
      if (m_v && red_out_rdy_o) m_v <= 1'b0;
      if (red_valid_o && red_ready_i) begin
        acc <= acc + beat_sum(red_vect_o, red_strb_o);
        if (red_tag_o) begin
          pend <= 1'b1;
          cnt  <= res_delay;
        end else begin
          m_v   <= 1'b1;
          m_tag <= 1'b0;
          m_res <= int_to_fp32(acc + beat_sum(red_vect_o, red_strb_o));
        end
      end else if (pend) begin
        if (cnt == 0) begin
          m_v   <= 1'b1;
          m_tag <= 1'b1;
          m_res <= int_to_fp32(acc);
          pend  <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  // ---------------- beat / clear monitor ----------------
  logic [3:0] strb_q[$];
  logic       tag_q[$];
  int         beat_cnt = 0;
  int         clear_cnt = 0;

  always @(posedge clk) begin
    if (rst_ni && red_valid_o && red_ready_i) begin
      strb_q.push_back(red_strb_o);
      tag_q.push_back(red_tag_o);
      beat_cnt <= beat_cnt + 1;
    end
    if (red_clear_o) clear_cnt <= clear_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [15:0] len, input logic exp_clear);
    int n;
    n = 0;
    cmd_valid_i = 1'b1;
    cmd_len_i   = len;
    #1;
    while (!cmd_ready_o && n < 50) begin
      step();
      n++;
    end
    check("cmd_ready_wait", 64'(n < 50), 64'd1);
    check("cmd_red_clear", 64'(red_clear_o), 64'(exp_clear));
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d);
    int n;
    n = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    #1;
    while (!in_ready_o && n < 50) begin
      step();
      n++;
    end
    check("beat_wait", 64'(n < 50), 64'd1);
    step();
    in_valid_i = 1'b0;
    in_data_i  = {$urandom, $urandom};
  endtask

  task automatic take_out(input string tag);
    int n;
    logic [31:0] e;
    n = 0;
    while (!out_valid_o && n < 50) begin
      step();
      n++;
    end
    check("out_valid_wait", 64'(n < 50), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check(tag, 64'(out_sum_o), 64'(e));
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check("post_out_idle", 64'(busy_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int b0;
  int c0;

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; cmd_valid_i = 1'b0; cmd_len_i = '0;
    in_valid_i = 1'b0; in_data_i = '0; red_ready_i = 1'b1; out_ready_i = 1'b0;
    step();
    step();
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_red_valid", 64'(red_valid_o), 64'd0);
    rst_ni = 1'b1;
    #1;
    check("post_rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("post_rst_state", 64'(dbg_state), 64'(RS_IDLE));
    check("post_rst_out_sum", 64'(out_sum_o), 64'd0);

    // 1: len=8, two full beats
    exp_q.push_back(32'h4140_0000);
    strb_q.delete(); tag_q.delete(); b0 = beat_cnt; c0 = clear_cnt;
    issue_cmd(16'd8, 1'b1);
    check("t1_state_stream", 64'(dbg_state), 64'(RS_STREAM));
    check("t1_cmd_ready_busy", 64'(cmd_ready_o), 64'd0);
    send_beat(pack4(H1, H1, H1, H1));
    send_beat(pack4(H2, H2, H2, H2));
    take_out("t1_sum");
    check("t1_beats", 64'(beat_cnt - b0), 64'd2);
    check("t1_strb0", 64'(strb_q[0]), 64'hF);
    check("t1_strb1", 64'(strb_q[1]), 64'hF);
    check("t1_tag0", 64'(tag_q[0]), 64'd0);
    check("t1_tag1", 64'(tag_q[1]), 64'd1);
    check("t1_clears", 64'(clear_cnt - c0), 64'd1);

    // 2: len=6, partial tail with garbage lanes
    exp_q.push_back(32'h41A8_0000);
    strb_q.delete(); tag_q.delete();
    issue_cmd(16'd6, 1'b1);
    send_beat(pack4(H1, H2, H3, H4));
    send_beat(pack4(H5, H6, HX, HX));
    take_out("t2_sum");
    check("t2_strb0", 64'(strb_q[0]), 64'hF);
    check("t2_strb1", 64'(strb_q[1]), 64'h3);
    check("t2_tag1", 64'(tag_q[1]), 64'd1);

    // 3: len=0, no reducer traffic
    b0 = beat_cnt; c0 = clear_cnt;
    exp_q.push_back(32'h0);
    issue_cmd(16'd0, 1'b0);
    check("t3_out_valid_next", 64'(out_valid_o), 64'd1);
    take_out("t3_sum");
    check("t3_beats", 64'(beat_cnt - b0), 64'd0);
    check("t3_clears", 64'(clear_cnt - c0), 64'd0);

    // 4: len=3 with reducer and output back-pressure
    exp_q.push_back(32'h4040_0000);
    strb_q.delete(); tag_q.delete(); b0 = beat_cnt;
    issue_cmd(16'd3, 1'b1);
    red_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = pack4(H1, H1, H1, HX);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("t4_in_ready_low", 64'(in_ready_o), 64'd0);
      check("t4_red_valid", 64'(red_valid_o), 64'd1);
      step();
    end
    check("t4_no_beat_yet", 64'(beat_cnt - b0), 64'd0);
    red_ready_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    check("t4_one_beat", 64'(beat_cnt - b0), 64'd1);
    check("t4_strb", 64'(strb_q[0]), 64'h7);
    check("t4_tag", 64'(tag_q[0]), 64'd1);
    for (int n = 0; n < 50 && !out_valid_o; n++) step();
    cmd_valid_i = 1'b1;
    cmd_len_i   = 16'd5;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t4_sum_hold", 64'(out_sum_o), 64'h4040_0000);
      check("t4_cmd_blocked", 64'(cmd_ready_o), 64'd0);
      step();
    end
    cmd_valid_i = 1'b0;
    take_out("t4_sum");
    check("t4_cmd_ready_after", 64'(cmd_ready_o), 64'd1);

    // 5: clear mid-row, then a fresh row
    b0 = beat_cnt; c0 = clear_cnt;
    issue_cmd(16'd16, 1'b1);
    send_beat(pack4(H1, H1, H1, H1));
    send_beat(pack4(H1, H1, H1, H1));
    in_valid_i = 1'b1;
    clear_i    = 1'b1;
    #1;
    check("t5_clear_pulse", 64'(red_clear_o), 64'd1);
    check("t5_in_ready_clear", 64'(in_ready_o), 64'd0);
    check("t5_cmd_ready_clear", 64'(cmd_ready_o), 64'd0);
    step();
    clear_i    = 1'b0;
    in_valid_i = 1'b0;
    #1;
    check("t5_state_idle", 64'(dbg_state), 64'(RS_IDLE));
    check("t5_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("t5_beats", 64'(beat_cnt - b0), 64'd2);
    check("t5_clears", 64'(clear_cnt - c0), 64'd2);
    exp_q.push_back(32'h4120_0000);
    issue_cmd(16'd4, 1'b1);
    send_beat(pack4(H1, H2, H3, H4));
    take_out("t5_sum");

    // 6: reset during DRAIN with a late reducer result
    res_delay = 6;
    issue_cmd(16'd4, 1'b1);
    send_beat(pack4(H2, H2, H2, H2));
    check("t6_state_drain", 64'(dbg_state), 64'(RS_DRAIN));
    rst_ni = 1'b0;
    step();
    check("t6_rst_busy", 64'(busy_o), 64'd0);
    check("t6_rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    check("t6_rst_out_valid", 64'(out_valid_o), 64'd0);
    check("t6_rst_out_rdy", 64'(red_out_rdy_o), 64'd0);
    check("t6_rst_out_sum", 64'(out_sum_o), 64'd0);
    step();
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("t6_late_ignored", 64'(out_valid_o), 64'd0);
    check("t6_state_idle", 64'(dbg_state), 64'(RS_IDLE));
    res_delay = 2;
    exp_q.push_back(32'h4080_0000);
    issue_cmd(16'd4, 1'b1);
    send_beat(pack4(H1, H1, H1, H1));
    take_out("t6_sum");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
